// File: rtl/id_ex_pipeline_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_reg
//   ID/EX pipeline register of the 5-stage MIPS datapath. Captures the decode
//   stage results (PC+4, register read data, sign-extended immediate, register
//   specifiers, shamt, main-control bits) and presents them to EX one cycle
//   later. Values are transported bit-exact.
//
//   Update priority at each rising Clk: Reset > Flush > Stall > normal load.
//     Flush  : every output (data included) loads 0, ValidOut loads 0.
//     Stall  : every output holds.
//     Load   : *Out <= *In, ValidOut <= ValidIn; when ValidIn=0 all control
//              outputs load 0 so a bubble can never write a register/memory.
//
// Ports
//   Clk, Reset (async, active-high), Stall, Flush, ValidIn
//   PCPlus4In/ReadData1In/ReadData2In/SignExtImmIn  [DATA_W-1:0]
//   RsIn/RtIn/RdIn/ShamtIn                          [REG_W-1:0]
//   RegWriteIn, MemToRegIn, MemReadIn, MemWriteIn, BranchIn, ALUSrcIn
//   RegDstIn [1:0], ALUOpIn [ALUOP_W-1:0]
//   *Out registered counterparts, ValidOut
//
// Optional feature (macro ID_EX_BUBBLE_COUNT_EN)
//   Adds BubbleCount[31:0]: counts edges that load a bubble (Flush, or
//   Stall=0 with ValidIn=0); stalled cycles never count; saturates at all-ones.
// ---------------------------------------------------------------------------
module id_ex_pipeline_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               ValidIn,
  input  logic [DATA_W-1:0]  PCPlus4In,
  input  logic [DATA_W-1:0]  ReadData1In,
  input  logic [DATA_W-1:0]  ReadData2In,
  input  logic [DATA_W-1:0]  SignExtImmIn,
  input  logic [REG_W-1:0]   RsIn,
  input  logic [REG_W-1:0]   RtIn,
  input  logic [REG_W-1:0]   RdIn,
  input  logic [REG_W-1:0]   ShamtIn,
  input  logic               RegWriteIn,
  input  logic               MemToRegIn,
  input  logic               MemReadIn,
  input  logic               MemWriteIn,
  input  logic               BranchIn,
  input  logic               ALUSrcIn,
  input  logic [1:0]         RegDstIn,
  input  logic [ALUOP_W-1:0] ALUOpIn,
  output logic [DATA_W-1:0]  PCPlus4Out,
  output logic [DATA_W-1:0]  ReadData1Out,
  output logic [DATA_W-1:0]  ReadData2Out,
  output logic [DATA_W-1:0]  SignExtImmOut,
  output logic [REG_W-1:0]   RsOut,
  output logic [REG_W-1:0]   RtOut,
  output logic [REG_W-1:0]   RdOut,
  output logic [REG_W-1:0]   ShamtOut,
  output logic               RegWriteOut,
  output logic               MemToRegOut,
  output logic               MemReadOut,
  output logic               MemWriteOut,
  output logic               BranchOut,
  output logic               ALUSrcOut,
  output logic [1:0]         RegDstOut,
  output logic [ALUOP_W-1:0] ALUOpOut,
  output logic               ValidOut
`ifdef ID_EX_BUBBLE_COUNT_EN
  ,
  output logic [31:0]        BubbleCount
`endif
);

  typedef struct packed {
    logic               valid;
    logic [DATA_W-1:0]  pc_plus4;
    logic [DATA_W-1:0]  read_data1;
    logic [DATA_W-1:0]  read_data2;
    logic [DATA_W-1:0]  sign_ext_imm;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   shamt;
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               alu_src;
    logic [1:0]         reg_dst;
    logic [ALUOP_W-1:0] alu_op;
  } stage_t;

  stage_t stage_in;
  stage_t stage_d;
  stage_t stage_q;

  always_comb begin
    stage_in              = '0;
    stage_in.valid        = ValidIn;
    stage_in.pc_plus4     = PCPlus4In;
    stage_in.read_data1   = ReadData1In;
    stage_in.read_data2   = ReadData2In;
    stage_in.sign_ext_imm = SignExtImmIn;
    stage_in.rs           = RsIn;
    stage_in.rt           = RtIn;
    stage_in.rd           = RdIn;
    stage_in.shamt        = ShamtIn;
    stage_in.reg_write    = RegWriteIn;
    stage_in.mem_to_reg   = MemToRegIn;
    stage_in.mem_read     = MemReadIn;
    stage_in.mem_write    = MemWriteIn;
    stage_in.branch       = BranchIn;
    stage_in.alu_src      = ALUSrcIn;
    stage_in.reg_dst      = RegDstIn;
    stage_in.alu_op       = ALUOpIn;
  end

  always_comb begin
    stage_d = stage_q;
    if (Flush) begin
      stage_d = '0;
    end else if (!Stall) begin
      stage_d = stage_in;
      // A non-valid slot keeps its data fields but carries no control, so the
      // bubble is harmless downstream.
      if (!ValidIn) begin
        stage_d.reg_write  = 1'b0;
        stage_d.mem_to_reg = 1'b0;
        stage_d.mem_read   = 1'b0;
        stage_d.mem_write  = 1'b0;
        stage_d.branch     = 1'b0;
        stage_d.alu_src    = 1'b0;
        stage_d.reg_dst    = '0;
        stage_d.alu_op     = '0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign ValidOut      = stage_q.valid;
  assign PCPlus4Out    = stage_q.pc_plus4;
  assign ReadData1Out  = stage_q.read_data1;
  assign ReadData2Out  = stage_q.read_data2;
  assign SignExtImmOut = stage_q.sign_ext_imm;
  assign RsOut         = stage_q.rs;
  assign RtOut         = stage_q.rt;
  assign RdOut         = stage_q.rd;
  assign ShamtOut      = stage_q.shamt;
  assign RegWriteOut   = stage_q.reg_write;
  assign MemToRegOut   = stage_q.mem_to_reg;
  assign MemReadOut    = stage_q.mem_read;
  assign MemWriteOut   = stage_q.mem_write;
  assign BranchOut     = stage_q.branch;
  assign ALUSrcOut     = stage_q.alu_src;
  assign RegDstOut     = stage_q.reg_dst;
  assign ALUOpOut      = stage_q.alu_op;

`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [31:0] bubble_cnt_d;
  logic [31:0] bubble_cnt_q;
  logic        bubble_load;

  always_comb begin
    bubble_load  = Flush | (~Stall & ~ValidIn);
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_load && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign BubbleCount = bubble_cnt_q;
`endif

endmodule
